pipe_datapath_core: RTL and testbench

- Parametrised 3-stage pipelined successor to the single-cycle 8-bit datapath: IF -> EX -> WB.
- Contains PC, 4-entry register file, ALU, WB-to-EX forwarding, branch flush, halt, and a retired-instruction counter.
- Instruction and data memories are external, with combinational read.
- Supports run mode (advance every clock) and single-step mode (advance on a debounced push-button pulse).

---
 rtl/pipe_datapath_core_if.sv | 39 +++
 rtl/pipe_datapath_core.sv | 200 ++++++++++++++++++++
 tb/tb_pipe_datapath_core.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_datapath_core_if.sv
// Bus bundle for pipe_datapath_core.
//   run_mode/step_pulse : advance control (core input)
//   imem_addr/imem_data : instruction fetch, combinational read
//   dmem_*              : data memory, combinational read, store strobe
//   wb_*, ovf*, halted,
//   retired             : retirement / status observation
// master = the core, slave = the environment (memories, bench).
interface pipe_datapath_core_if #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 16
);
  logic              run_mode;
  logic              step_pulse;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_data;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;
  logic              ovf;
  logic              ovf_sticky;
  logic              halted;
  logic [CNT_W-1:0]  retired;

  modport master (
    input  run_mode, step_pulse, imem_data, dmem_rdata,
    output imem_addr, dmem_addr, dmem_wdata, dmem_we,
           wb_data, wb_valid, ovf, ovf_sticky, halted, retired
  );

  modport slave (
    output run_mode, step_pulse, imem_data, dmem_rdata,
    input  imem_addr, dmem_addr, dmem_wdata, dmem_we,
           wb_data, wb_valid, ovf, ovf_sticky, halted, retired
  );
endinterface

// File: rtl/pipe_datapath_core.sv
// pipe_datapath_core: 3-stage (IF -> EX -> WB) pipelined 4-register datapath.
// Ports:
//   clk          system clock
//   rst_general  asynchronous active-low reset
//   bus          pipe_datapath_core_if.master (memories, control, status)
// Advance semantics: there is no per-stage handshake. A single qualifier
// adv = !halted && (run_mode || step_pulse) acts as the pipeline enable:
// when adv=1 every stage moves on the rising edge, when adv=0 all state holds
// and no store strobe is issued. wb_valid marks a valid non-NOP instruction
// in WB; it retires on the next edge where adv=1.
// The run/halt FSM state is visible on bus.halted.
module pipe_datapath_core #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_general,
  pipe_datapath_core_if.master bus
);

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_J    = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic {ST_RUN, ST_HALT} core_state_t;
  core_state_t state_q, state_d;

  // Fetch / IF-ID
  logic [PC_W-1:0]   pc_q;
  logic [15:0]       ifid_instr_q;
  logic [PC_W-1:0]   ifid_pc_q;
  logic              ifid_valid_q;
  // EX-WB
  logic              exwb_valid_q;
  logic              exwb_we_q;
  logic              exwb_ovf_q;
  logic [1:0]        exwb_dst_q;
  logic [DATA_W-1:0] exwb_data_q;
  // Architectural state
  logic [DATA_W-1:0] rf_q [4];
  logic [CNT_W-1:0]  retired_q;
  logic              sticky_q;

  logic adv;
  assign adv = (state_q == ST_RUN) && (bus.run_mode || bus.step_pulse);

  // Decode
  logic [3:0] op;
  logic [1:0] rs, rt, rd;
  logic [7:0] imm;
  assign op  = ifid_instr_q[15:12];
  assign rs  = ifid_instr_q[11:10];
  assign rt  = ifid_instr_q[9:8];
  assign rd  = ifid_instr_q[7:6];
  assign imm = ifid_instr_q[7:0];

  // Operand read with WB->EX forwarding. r0 is never written, so a plain
  // register-file read of index 0 already returns 0.
  logic fwd_rs, fwd_rt;
  logic [DATA_W-1:0] rs_val, rt_val;
  assign fwd_rs = exwb_valid_q && exwb_we_q && (exwb_dst_q != 2'd0) && (exwb_dst_q == rs);
  assign fwd_rt = exwb_valid_q && exwb_we_q && (exwb_dst_q != 2'd0) && (exwb_dst_q == rt);
  assign rs_val = fwd_rs ? exwb_data_q : rf_q[rs];
  assign rt_val = fwd_rt ? exwb_data_q : rf_q[rt];

  logic [DATA_W-1:0] imm_ext, sum, diff, addi_sum;
  logic              add_ovf, sub_ovf, addi_ovf, slt;
  assign imm_ext  = DATA_W'($signed(imm));
  assign sum      = rs_val + rt_val;
  assign diff     = rs_val - rt_val;
  assign addi_sum = rs_val + imm_ext;
  assign add_ovf  = (rs_val[DATA_W-1] == rt_val[DATA_W-1]) && (sum[DATA_W-1] != rs_val[DATA_W-1]);
  assign sub_ovf  = (rs_val[DATA_W-1] != rt_val[DATA_W-1]) && (diff[DATA_W-1] != rs_val[DATA_W-1]);
  assign addi_ovf = (rs_val[DATA_W-1] == imm_ext[DATA_W-1]) && (addi_sum[DATA_W-1] != rs_val[DATA_W-1]);
  assign slt      = $signed(rs_val) < $signed(rt_val);

  logic [PC_W-1:0] beq_target, j_target;
  assign beq_target = ifid_pc_q + PC_W'(1) + PC_W'($signed(imm));
  assign j_target   = PC_W'(imm);

  // ALU result kept separate from the load mux: dmem_addr must not depend
  // on dmem_rdata through the same process.
  logic [DATA_W-1:0] alu_res;
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:                alu_res = sum;
      OP_SUB:                alu_res = diff;
      OP_AND:                alu_res = rs_val & rt_val;
      OP_OR:                 alu_res = rs_val | rt_val;
      OP_SLT:                alu_res = slt ? DATA_W'(1) : '0;
      OP_ADDI, OP_LW, OP_SW: alu_res = addi_sum;
      default:               alu_res = '0;
    endcase
  end

  logic [DATA_W-1:0] ex_result;
  logic              ex_we, ex_ovf, ex_retire, ex_store, ex_halt, br_taken;
  logic [1:0]        ex_dst;
  logic [PC_W-1:0]   br_target;
  always_comb begin
    ex_result = alu_res;
    ex_we     = 1'b0;
    ex_dst    = rd;
    ex_ovf    = 1'b0;
    ex_retire = 1'b0;
    ex_store  = 1'b0;
    ex_halt   = 1'b0;
    br_taken  = 1'b0;
    br_target = beq_target;
    case (op)
      OP_ADD:  begin ex_we = 1'b1; ex_retire = 1'b1; ex_ovf = add_ovf; end
      OP_SUB:  begin ex_we = 1'b1; ex_retire = 1'b1; ex_ovf = sub_ovf; end
      OP_AND, OP_OR, OP_SLT: begin ex_we = 1'b1; ex_retire = 1'b1; end
      OP_ADDI: begin ex_we = 1'b1; ex_retire = 1'b1; ex_dst = rt; ex_ovf = addi_ovf; end
      OP_LW:   begin ex_we = 1'b1; ex_retire = 1'b1; ex_dst = rt; ex_result = bus.dmem_rdata; end
      OP_SW:   begin ex_retire = 1'b1; ex_store = 1'b1; ex_result = '0; end
      OP_BEQ:  begin ex_retire = 1'b1; ex_result = '0; br_taken = (rs_val == rt_val); end
      OP_J:    begin ex_retire = 1'b1; ex_result = '0; br_taken = 1'b1; br_target = j_target; end
      OP_HALT: begin ex_halt = 1'b1; ex_result = '0; end
      default: ex_result = '0;
    endcase
  end

  // Run/halt FSM
  always_ff @(posedge clk or negedge rst_general) begin
    if (!rst_general) state_q <= ST_RUN;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && adv && ifid_valid_q && ex_halt) state_d = ST_HALT;
  end

  // Pipeline and architectural state
  always_ff @(posedge clk or negedge rst_general) begin
    if (!rst_general) begin
      pc_q         <= '0;
      ifid_instr_q <= '0;
      ifid_pc_q    <= '0;
      ifid_valid_q <= 1'b0;
      exwb_valid_q <= 1'b0;
      exwb_we_q    <= 1'b0;
      exwb_ovf_q   <= 1'b0;
      exwb_dst_q   <= '0;
      exwb_data_q  <= '0;
      retired_q    <= '0;
      sticky_q     <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else if (adv) begin
      // WB: retire the instruction leaving EX/WB
      if (exwb_valid_q) begin
        if (exwb_we_q && exwb_dst_q != 2'd0) rf_q[exwb_dst_q] <= exwb_data_q;
        if (retired_q != {CNT_W{1'b1}}) retired_q <= retired_q + CNT_W'(1);
        sticky_q <= sticky_q | exwb_ovf_q;
      end
      // EX -> WB; NOPs and HALT never enter WB as valid
      exwb_valid_q <= ifid_valid_q && ex_retire;
      exwb_we_q    <= ex_we;
      exwb_ovf_q   <= ex_ovf;
      exwb_dst_q   <= ex_dst;
      exwb_data_q  <= ex_result;
      // IF: halt and taken branches discard the word being fetched
      if (ifid_valid_q && ex_halt) begin
        ifid_valid_q <= 1'b0;
      end else if (ifid_valid_q && br_taken) begin
        pc_q         <= br_target;
        ifid_valid_q <= 1'b0;
      end else begin
        ifid_instr_q <= bus.imem_data;
        ifid_pc_q    <= pc_q;
        ifid_valid_q <= 1'b1;
        pc_q         <= pc_q + PC_W'(1);
      end
    end
  end

  // Outputs are gated by stage valid so reset drives them all to 0
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_addr  = ifid_valid_q ? alu_res : '0;
  assign bus.dmem_wdata = ifid_valid_q ? rt_val : '0;
  assign bus.dmem_we    = adv && ifid_valid_q && ex_store;
  assign bus.wb_valid   = exwb_valid_q;
  assign bus.wb_data    = exwb_valid_q ? exwb_data_q : '0;
  assign bus.ovf        = exwb_valid_q && exwb_ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_pipe_datapath_core.sv
`timescale 1ns/1ps
module tb_pipe_datapath_core;
  localparam int DATA_W = 8;
  localparam int PC_W   = 8;
  localparam int CNT_W  = 16;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_general = 1'b0;
  always #5 clk = ~clk;

  pipe_datapath_core_if #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) bus ();
  pipe_datapath_core #(.DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_general(rst_general), .bus(bus)
  );

  // Memories
  logic [15:0] imem     [256];
  logic [7:0]  dmem     [256];
  logic [7:0]  init_mem [256];
  assign bus.imem_data  = imem[bus.imem_addr];
  assign bus.dmem_rdata = dmem[bus.dmem_addr];
  always @(posedge clk) begin
    if (!rst_general) begin
      for (int i = 0; i < 256; i++) dmem[i] <= init_mem[i];
    end else if (bus.dmem_we) begin
      dmem[bus.dmem_addr] <= bus.dmem_wdata;
    end
  end

  // Scoreboard state
  logic [8:0]  exp_q[$];   // {ovf, wb_data}
  logic [15:0] st_q[$];    // {addr, wdata}
  logic [7:0]  ret_pc_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int bubbles, we_cycles;
  logic seen_ret, chk_en = 1'b0;
  int m_retired;
  logic m_sticky;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops and compares on every advancing cycle with a retiring WB
  always @(negedge clk) begin
    if (rst_general && chk_en) begin
      if (bus.wb_valid && (bus.run_mode || bus.step_pulse)) begin
        ret_pc_q.push_back(bus.imem_addr);
        seen_ret = 1'b1;
        if (exp_q.size() == 0) check("wb_unexpected", 32'(exp_q.size()), 32'd1);
        else check("wb", 32'({bus.ovf, bus.wb_data}), 32'(exp_q.pop_front()));
      end
      if (bus.dmem_we) begin
        we_cycles++;
        if (st_q.size() == 0) check("store_unexpected", 32'(st_q.size()), 32'd1);
        else check("store", 32'({bus.dmem_addr, bus.dmem_wdata}), 32'(st_q.pop_front()));
      end
      if (!bus.wb_valid && !bus.halted && seen_ret && (bus.run_mode || bus.step_pulse))
        bubbles++;
    end
  end

  // Reference model: architectural (one instruction at a time) interpreter
  function automatic int sv8(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  task automatic run_model();
    int pc, npc, s, res, addr, dst, rs_v, rt_v, imm, op;
    int r[4];
    int mem[256];
    logic [15:0] ins;
    logic ovf, we;
    for (int i = 0; i < 4; i++) r[i] = 0;
    for (int i = 0; i < 256; i++) mem[i] = int'(init_mem[i]);
    pc = 0; m_retired = 0; m_sticky = 1'b0;
    for (int steps = 0; steps < 4000; steps++) begin
      ins = imem[pc];
      op = int'(ins[15:12]);
      rs_v = r[ins[11:10]];
      rt_v = r[ins[9:8]];
      imm = int'(ins[7:0]);
      npc = (pc + 1) % 256;
      res = 0; ovf = 1'b0; we = 1'b0; dst = 0;
      if (op == 15) break;
      if (op == 0 || op >= 11) begin pc = npc; continue; end
      case (op)
        1: begin s = sv8(rs_v) + sv8(rt_v); ovf = (s > 127 || s < -128); res = s & 255; we = 1'b1; dst = int'(ins[7:6]); end
        2: begin s = sv8(rs_v) - sv8(rt_v); ovf = (s > 127 || s < -128); res = s & 255; we = 1'b1; dst = int'(ins[7:6]); end
        3: begin res = rs_v & rt_v; we = 1'b1; dst = int'(ins[7:6]); end
        4: begin res = rs_v | rt_v; we = 1'b1; dst = int'(ins[7:6]); end
        5: begin res = (sv8(rs_v) < sv8(rt_v)) ? 1 : 0; we = 1'b1; dst = int'(ins[7:6]); end
        6: begin s = sv8(rs_v) + sv8(imm); ovf = (s > 127 || s < -128); res = s & 255; we = 1'b1; dst = int'(ins[9:8]); end
        7: begin addr = (rs_v + sv8(imm)) & 255; res = mem[addr]; we = 1'b1; dst = int'(ins[9:8]); end
        8: begin addr = (rs_v + sv8(imm)) & 255; mem[addr] = rt_v; st_q.push_back({8'(addr), 8'(rt_v)}); end
        9: if (rs_v == rt_v) npc = (pc + 1 + sv8(imm)) & 255;
        default: npc = imm;   // J
      endcase
      if (we && dst != 0) r[dst] = res;
      exp_q.push_back({ovf, 8'(res)});
      m_retired++;
      m_sticky = m_sticky | ovf;
      pc = npc;
    end
  endtask

  // Encoders / stimulus
  function automatic logic [15:0] enc_r(input int op, input int rd, input int rs, input int rt);
    return {4'(op), 2'(rs), 2'(rt), 2'(rd), 6'd0};
  endfunction
  function automatic logic [15:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {4'(op), 2'(rs), 2'(rt), 8'(imm)};
  endfunction
  function automatic logic [15:0] rand_instr(input int pc);
    int sel, op, imm;
    sel = $urandom_range(0, 11);
    op  = (sel == 11) ? $urandom_range(11, 14) : sel;
    imm = $urandom_range(0, 255);
    if (op == 9)  imm = $urandom_range(0, 4);
    if (op == 10) imm = pc + 1 + $urandom_range(0, 3);
    return enc_i(op, $urandom_range(0, 3), $urandom_range(0, 3), imm);
  endfunction

  function automatic logic [31:0] out_vec();
    return 32'({bus.imem_addr, bus.wb_data, bus.wb_valid, bus.ovf, bus.ovf_sticky,
                bus.halted, bus.dmem_we, bus.dmem_addr});
  endfunction

  // Driver tasks
  task automatic hold_reset();
    @(posedge clk); #1;
    rst_general = 1'b0;
    chk_en = 1'b0;
    exp_q.delete(); st_q.delete(); ret_pc_q.delete();
    bubbles = 0; we_cycles = 0; seen_ret = 1'b0;
    for (int i = 0; i < 256; i++) begin
      init_mem[i] = 8'($urandom_range(0, 255));
      imem[i] = 16'hF000;
    end
  endtask

  task automatic release_reset(input logic rm, input logic use_model);
    if (use_model) run_model();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", out_vec(), 32'd0);
    check("reset_wdata", 32'(bus.dmem_wdata), 32'd0);
    check("reset_retired", 32'(bus.retired), 32'd0);
    bus.run_mode = rm;
    bus.step_pulse = 1'b0;
    chk_en = use_model;
    rst_general = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    bus.step_pulse = 1'($urandom_range(0, 1));
  endtask

  task automatic run_until_halt(input int budget);
    int n;
    n = 0;
    while (!bus.halted && n < budget) begin tick(); n++; end
    check("halt_reached", 32'(bus.halted), 32'd1);
    repeat (3) tick();
    check("exp_drained", 32'(exp_q.size()), 32'd0);
    check("stores_drained", 32'(st_q.size()), 32'd0);
    check("retired", 32'(bus.retired), 32'(m_retired));
    check("ovf_sticky", 32'(bus.ovf_sticky), 32'(m_sticky));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int moved, n;
    bus.run_mode = 1'b0;
    bus.step_pulse = 1'b0;

    // 1: forwarding chain
    hold_reset();
    imem[0] = enc_i(6, 0, 1, 5);
    imem[1] = enc_i(6, 0, 2, 3);
    imem[2] = enc_r(1, 3, 1, 2);
    release_reset(1'b1, 1'b1);
    run_until_halt(100);
    check("t1_retired_3", 32'(bus.retired), 32'd3);

    // 2: signed overflow
    hold_reset();
    imem[0] = enc_i(6, 0, 1, 8'h7F);
    imem[1] = enc_i(6, 1, 1, 1);
    imem[2] = 16'h0000;
    release_reset(1'b1, 1'b1);
    run_until_halt(100);
    check("t2_sticky", 32'(bus.ovf_sticky), 32'd1);

    // 3: store then load
    hold_reset();
    imem[0] = enc_i(6, 0, 1, 8'h2A);
    imem[1] = enc_i(8, 0, 1, 8'h10);
    imem[2] = enc_i(7, 0, 2, 8'h10);
    imem[3] = enc_r(1, 3, 2, 0);
    release_reset(1'b1, 1'b1);
    run_until_halt(100);
    check("t3_we_cycles", 32'(we_cycles), 32'd1);
    check("t3_mem", 32'(dmem[8'h10]), 32'h2A);

    // 4: taken branch at pc=4
    hold_reset();
    for (int i = 0; i < 4; i++) imem[i] = enc_i(6, 0, 1, i + 1);
    imem[4] = enc_i(9, 0, 0, 2);
    imem[5] = enc_i(6, 0, 1, 8'h55);
    imem[6] = enc_i(6, 0, 2, 8'h66);
    imem[7] = enc_i(6, 0, 3, 8'h77);
    release_reset(1'b1, 1'b1);
    run_until_halt(100);
    check("t4_bubbles", 32'(bubbles), 32'd1);
    check("t4_ret_count", 32'(ret_pc_q.size()), 32'd6);
    if (ret_pc_q.size() > 4) check("t4_pc_after_beq", 32'(ret_pc_q[4]), 32'd7);

    // 5: single-step mode
    hold_reset();
    imem[0] = enc_i(6, 0, 1, 5);
    imem[1] = enc_i(6, 0, 2, 3);
    imem[2] = enc_r(1, 3, 1, 2);
    release_reset(1'b0, 1'b1);
    moved = 0;
    repeat (20) begin
      @(posedge clk); #1;
      bus.step_pulse = 1'b0;
      if (bus.imem_addr != 8'd0) moved++;
    end
    check("t5_idle_pc_hold", 32'(moved), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1; bus.step_pulse = 1'b1;
      @(posedge clk); #1; bus.step_pulse = 1'b0;
      check("t5_step_pc", 32'(bus.imem_addr), 32'(k));
    end
    run_until_halt(400);
    check("t5_retired_3", 32'(bus.retired), 32'd3);

    // 6: jump wrap, then asynchronous reset mid-program
    hold_reset();
    imem[0]     = enc_i(10, 0, 0, 8'hFE);
    imem[8'hFE] = enc_i(6, 0, 1, 9);
    imem[8'hFF] = enc_i(6, 0, 2, 1);
    release_reset(1'b1, 1'b0);
    n = 0;
    while (bus.imem_addr != 8'hFF && n < 50) begin @(posedge clk); #1; n++; end
    check("t6_reach_ff", 32'(bus.imem_addr), 32'hFF);
    @(posedge clk); #1;
    check("t6_pc_wrap", 32'(bus.imem_addr), 32'd0);
    repeat (2) @(posedge clk);
    check("t6_pre_reset_retired", 32'(bus.retired != 0), 32'd1);
    @(posedge clk); #3;
    rst_general = 1'b0;
    #1;
    check("t6_async_outputs", out_vec(), 32'd0);
    check("t6_async_retired", 32'(bus.retired), 32'd0);
    hold_reset();
    imem[0] = enc_r(1, 3, 1, 2);
    imem[1] = enc_i(6, 1, 1, 1);
    imem[2] = enc_i(6, 2, 2, 0);
    release_reset(1'b1, 1'b1);
    run_until_halt(100);

    // 7: random programs, random run/step mode
    for (int t = 0; t < 10; t++) begin
      int len;
      hold_reset();
      len = $urandom_range(8, 24);
      for (int p = 0; p < len; p++) imem[p] = rand_instr(p);
      release_reset(1'($urandom_range(0, 1)), 1'b1);
      run_until_halt(2000);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
